sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
- Single-port controller between the CPU's request/ack memory bus and one 1M x 32 asynchronous SRAM (BaseRAM or ExtRAM) inside thinpad_top.
- Sequences ce_n/oe_n/we_n/be_n and the tri-state data bus, with setup/pulse/hold timing that satisfies the board SRAM model.
- Two instances are used: one per RAM.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 32, data width; must equal 4*8.
- RD_CYCLES, 2, cycles oe_n is held low before data is sampled (>=1).
- WE_CYCLES, 1, cycles we_n is held low during a write (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request valid; held until ack.
- we  in  1  1=write, 0=read; qualified by req.
- addr  in  ADDR_W  word address.
- be  in  4  byte enables, active-high; write only.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid when ack=1.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high from the accept edge until the ack cycle, inclusive.
- ram_data  inout  DATA_W  SRAM data bus.
- ram_addr  out  ADDR_W  SRAM address.
- ram_be_n  out  4  SRAM byte enables, active-low.
- ram_ce_n  out  1  SRAM chip enable.
- ram_oe_n  out  1  SRAM output enable.
- ram_we_n  out  1  SRAM write enable.

Behaviour:
- One clock domain (clk); synchronous active-high reset (rst).
- All outputs are registered.
- Reset values:
  - ack=0, busy=0, rdata=0, ram_addr=0, ram_be_n=4'hF.
  - ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_data=Z.
  - State is IDLE; counter=0.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - On req=1, latch addr/be/wdata/we at edge E0.
  - If we=0, go to RD; if we=1, go to WR_SETUP.
- RD:
  - ce_n=0, oe_n=0, be_n=0000, bus Z.
  - Lasts RD_CYCLES cycles. At the final edge, ram_data is captured into rdata; go to DONE.
- WR_SETUP (1 cycle):
  - ce_n=0, we_n=1, be_n=~be, bus driven with wdata.
- WR_PULSE:
  - we_n=0 for WE_CYCLES cycles; address, be_n and data held stable.
- WR_HOLD (1 cycle):
  - we_n=1; data still driven; ce_n=0.
  - Bus released at the exit edge. Next state is DONE.
- DONE (1 cycle):
  - ack=1; ce_n=oe_n=we_n=1; bus Z; return to IDLE.
  - req is not sampled in DONE, so back-to-back requests have a 1-cycle gap.
- Latency from the accept cycle to the ack cycle: read = RD_CYCLES+1; write = WE_CYCLES+3.
- oe_n and we_n are never low simultaneously. The data bus is driven only in WR_* states.
- If req drops or addr/wdata changes mid-transaction, the latched values are used and the transaction completes (master protocol violation, not an error).
- If rst is asserted mid-transaction, the next edge returns everything to reset values. No ack is produced; the master must reissue.
- Address: no wrap logic; addr is used verbatim.
- Counter width is $clog2(max(RD_CYCLES,WE_CYCLES)+1).

Optional Feature:
- Macro: SRAM_READ_BUFFER_EN.
- Defined:
  - A one-entry read buffer (tag = addr, valid bit) is added.
  - A read hitting a valid tag goes IDLE->DONE with rdata taken from the buffer: latency 1, no SRAM strobes.
  - Every completed SRAM read refills the buffer.
  - A write to the same addr updates the buffered bytes selected by be at the WR_SETUP edge.
  - rst clears the valid bit.
- Undefined: no buffer logic; every read accesses the SRAM.

Decomposition:
- Package sram_pkg holds:
  - The state enum sram_state_t.
  - Localparams SRAM_BE_ALL_N=4'h0 and SRAM_BE_NONE_N=4'hF.
  - A req struct {we, addr, be, wdata} used by the bus arbiter.
- Sub-module sram_rdbuf: tag/valid/data registers plus byte-merge logic. It is instantiated only under SRAM_READ_BUFFER_EN.

Test Plan:
- Reset: after rst=1 for 2 cycles -> ce_n=oe_n=we_n=1, be_n=F, ram_data=Z, ack=0.
- Write addr=20'h00010, wdata=32'hDEADBEEF, be=4'hF -> we_n low exactly 1 cycle; ack 4 cycles after accept; the SRAM model holds DEADBEEF at word 0x10.
- Read addr=20'h00010 -> oe_n low for 2 cycles; ack 3 cycles after accept with rdata=32'hDEADBEEF; we_n stays 1 throughout.
- Partial write be=4'b0010, wdata=32'h0000AB00 to 0x10, then read -> rdata=32'hDEADABEF.
- rst asserted during WR_PULSE -> next edge we_n=1, bus Z, no ack. A subsequent read of 0x10 completes normally.
- SRAM_READ_BUFFER_EN defined: two consecutive reads of 0x10 -> the second acks 1 cycle after accept with oe_n never low. A write to 0x10 followed by a read returns the new data.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the asynchronous SRAM controller.
// The read buffer (SRAM_READ_BUFFER_EN) uses be_merge for byte-wise updates.
package sram_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 32;

   // Active-low byte-enable patterns driven onto ram_be_n
   localparam logic [3:0] SRAM_BE_ALL_N  = 4'h0;
   localparam logic [3:0] SRAM_BE_NONE_N = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE
   } sram_state_t;

   // Request bundle as presented by the bus arbiter
   typedef struct packed {
      logic                   we;
      logic [SRAM_ADDR_W-1:0] addr;
      logic [3:0]             be;
      logic [SRAM_DATA_W-1:0] wdata;
   } sram_req_t;

   // Replace the bytes of old_d selected by be with the matching bytes of new_d
   function automatic logic [31:0] be_merge(input logic [31:0] old_d,
                                            input logic [31:0] new_d,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_d;
      for (int i = 0; i < 4; i++)
         if (be[i]) res[8*i +: 8] = new_d[8*i +: 8];
      return res;
   endfunction

endpackage

// File: rtl/sram_rdbuf.sv
// sram_rdbuf: one-entry read buffer (tag, valid, data) for sram_ctrl.
// Only instantiated when SRAM_READ_BUFFER_EN is defined.
module sram_rdbuf #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data,
   input  logic              fill_en,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3:0]        wr_be,
   input  logic [DATA_W-1:0] wr_data
);
   import sram_pkg::*;

   logic              vld;
   logic [ADDR_W-1:0] tag;
   logic [DATA_W-1:0] data;

   assign hit      = vld && (tag == lookup_addr);
   assign hit_data = data;

   // Refill on every completed SRAM read; keep buffered bytes coherent with writes
   always_ff @(posedge clk) begin
      if (rst) begin
         vld  <= 1'b0;
         tag  <= '0;
         data <= '0;
      end else if (fill_en) begin
         vld  <= 1'b1;
         tag  <= fill_addr;
         data <= fill_data;
      end else if (wr_en && vld && (tag == wr_addr)) begin
         data <= be_merge(data, wr_data, wr_be);
      end
   end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: request/ack bus to 1M x 32 asynchronous SRAM sequencer.
// All SRAM strobes are registered from the next state, so they change only
// on clock edges. Optional one-entry read buffer: SRAM_READ_BUFFER_EN.
module sram_ctrl #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 32,
   parameter int RD_CYCLES = 2,
   parameter int WE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              busy,
   inout  wire  [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_be_n,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n
);
   import sram_pkg::*;

   localparam int CNT_MAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

   sram_state_t       state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [3:0]        be_q, be_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic [DATA_W-1:0] rdata_nxt;
   logic              drv_q, drv_nxt;
   logic              ce_n_nxt, oe_n_nxt, we_n_nxt, ack_nxt, busy_nxt;
   logic [3:0]        be_n_nxt;
   logic              rd_done;

   // ram_addr doubles as the latched request address
   assign ram_data = drv_q ? wdata_q : 'z;
   assign rd_done  = (state == RD) && (cnt == RD_LAST);

`ifdef SRAM_READ_BUFFER_EN
   logic              buf_hit;
   logic [DATA_W-1:0] buf_data;

   sram_rdbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_rdbuf (
      .clk         (clk),
      .rst         (rst),
      .lookup_addr (addr),
      .hit         (buf_hit),
      .hit_data    (buf_data),
      .fill_en     (rd_done),
      .fill_addr   (ram_addr),
      .fill_data   (ram_data),
      .wr_en       (state == WR_SETUP),
      .wr_addr     (ram_addr),
      .wr_be       (be_q),
      .wr_data     (wdata_q)
   );
`endif

   // Next state, request latch and read capture, then strobes from next state
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = ram_addr;
      be_nxt    = be_q;
      wdata_nxt = wdata_q;
      rdata_nxt = rdata;
      case (state)
         IDLE: begin
            if (req) begin
               addr_nxt  = addr;
               be_nxt    = be;
               wdata_nxt = wdata;
               cnt_nxt   = '0;
               if (we) begin
                  state_nxt = WR_SETUP;
`ifdef SRAM_READ_BUFFER_EN
               end else if (buf_hit) begin
                  state_nxt = DONE;
                  rdata_nxt = buf_data;
`endif
               end else begin
                  state_nxt = RD;
               end
            end
         end
         RD: begin
            if (cnt == RD_LAST) begin
               state_nxt = DONE;
               rdata_nxt = ram_data;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WR_SETUP: begin
            state_nxt = WR_PULSE;
            cnt_nxt   = '0;
         end
         WR_PULSE: begin
            if (cnt == WE_LAST) state_nxt = WR_HOLD;
            else                cnt_nxt   = cnt + 1'b1;
         end
         WR_HOLD:  state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase

      ce_n_nxt = !(state_nxt inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
      oe_n_nxt = (state_nxt != RD);
      we_n_nxt = (state_nxt != WR_PULSE);
      drv_nxt  = (state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD});
      ack_nxt  = (state_nxt == DONE);
      busy_nxt = (state_nxt != IDLE);
      be_n_nxt = SRAM_BE_NONE_N;
      if (state_nxt == RD) be_n_nxt = SRAM_BE_ALL_N;
      else if (drv_nxt)    be_n_nxt = ~be_nxt;
   end

   // State register and registered outputs; reset aborts any transaction silently
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ram_addr <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         rdata    <= '0;
         drv_q    <= 1'b0;
         ram_ce_n <= 1'b1;
         ram_oe_n <= 1'b1;
         ram_we_n <= 1'b1;
         ram_be_n <= SRAM_BE_NONE_N;
         ack      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ram_addr <= addr_nxt;
         be_q     <= be_nxt;
         wdata_q  <= wdata_nxt;
         rdata    <= rdata_nxt;
         drv_q    <= drv_nxt;
         ram_ce_n <= ce_n_nxt;
         ram_oe_n <= oe_n_nxt;
         ram_we_n <= we_n_nxt;
         ram_be_n <= be_n_nxt;
         ack      <= ack_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule
